// File: rtl/ddfs_pkg.sv
// Shared widths, midscale constant and the quarter-wave sine table for the ddfs block.
// The table is evaluated at elaboration time, so it becomes constant ROM contents.
package ddfs_pkg;

  localparam int ACC_W     = 23;
  localparam int OUT_W     = 8;
  localparam int LUT_AW    = 8;
  localparam int PHASE_W   = LUT_AW + 2;
  localparam int MAG_W     = OUT_W - 1;
  localparam int LUT_DEPTH = 1 << LUT_AW;

  localparam logic [OUT_W-1:0] MIDSCALE = 8'd128;

  typedef logic [LUT_DEPTH-1:0][MAG_W-1:0] rom_t;

  // Sample at the centre of each bin (i+0.5) so the fold at the quadrant
  // edges is exactly symmetric and no table entry is duplicated.
  function automatic rom_t gen_sine_rom();
    rom_t r;
    real  x;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      x    = 127.0 * $sin(2.0 * 3.14159265358979323846 * (real'(i) + 0.5)
                          / real'(4 * LUT_DEPTH));
      r[i] = MAG_W'($rtoi(x + 0.5));
    end
    return r;
  endfunction

endpackage

// File: rtl/ddfs_sine_lut.sv
// Quarter-wave sine ROM: folds the phase into a table index and registers
// the magnitude together with the half-cycle sign bit.
module ddfs_sine_lut
  import ddfs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase,
  output logic               sign_o,
  output logic [MAG_W-1:0]   mag_o
);

  localparam rom_t ROM = gen_sine_rom();

  logic [1:0]        quad;
  logic [LUT_AW-1:0] addr;
  logic [LUT_AW-1:0] idx;
  logic              sign_d, sign_q;
  logic [MAG_W-1:0]  mag_d, mag_q;

  // Quadrants 1 and 3 run the table backwards; quadrants 2 and 3 are negative.
  always_comb begin
    quad   = phase[PHASE_W-1 -: 2];
    addr   = phase[LUT_AW-1:0];
    idx    = quad[0] ? ~addr : addr;
    sign_d = quad[1];
    mag_d  = ROM[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
    end else begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
    end
  end

  assign sign_o = sign_q;
  assign mag_o  = mag_q;

endmodule

// File: rtl/ddfs.sv
// Direct digital frequency synthesizer: phase accumulator, quarter-wave ROM
// and a registered offset-binary output for an external DAC.
module ddfs
  import ddfs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] fcontrol,
  output logic [OUT_W-1:0] outp
);

  logic [ACC_W-1:0]   acc_d, acc_q;
  logic [PHASE_W-1:0] phase;
  logic               lut_sign;
  logic [MAG_W-1:0]   lut_mag;
  logic [OUT_W-1:0]   outp_d, outp_q;

  // Accumulator wraps naturally at 2^ACC_W; phase is never cleared except by reset.
  always_comb begin
    acc_d = acc_q + fcontrol;
    phase = acc_q[ACC_W-1 -: PHASE_W];
  end

  ddfs_sine_lut u_lut (
    .clk    (clk),
    .rst    (rst),
    .phase  (phase),
    .sign_o (lut_sign),
    .mag_o  (lut_mag)
  );

  // Negative half maps to 127-mag so both halves span exactly 0..255.
  always_comb begin
    if (lut_sign) outp_d = (MIDSCALE - 8'd1) - {1'b0, lut_mag};
    else          outp_d = MIDSCALE + {1'b0, lut_mag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      outp_q <= MIDSCALE;
    end else begin
      acc_q  <= acc_d;
      outp_q <= outp_d;
    end
  end

  assign outp = outp_q;

endmodule

// File: tb/tb_ddfs.sv
// Bench for ddfs: constant vector table, directed corner sequences and random
// tuning words checked against a floating-point phase-to-sine reference model.
module tb_ddfs;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] fcontrol;
  logic [7:0]  outp;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: true phase and pending outputs in pipeline order.
  logic [22:0] acc_m;
  logic [7:0]  exp_q[$];

  ddfs dut (
    .clk      (clk),
    .rst      (rst),
    .fcontrol (fcontrol),
    .outp     (outp)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_sample(input logic [22:0] acc);
    int  p;
    real s;
    int  m;
    p = int'(acc >> 13);
    s = $sin(2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / 1024.0);
    if (s < 0.0) s = -s;
    m = $rtoi(127.0 * s + 0.5);
    return (p < 512) ? 8'(128 + m) : 8'(127 - m);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, got, lo, hi, $time);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, sample 1 ns later.
  task automatic tick(input logic r, input logic [22:0] fc, input string name);
    logic [7:0] exp;
    rst      = r;
    fcontrol = fc;
    @(posedge clk);
    if (r) begin
      acc_m = '0;
      exp_q.delete();
      exp_q.push_back(8'd128);
      exp = 8'd128;
    end else begin
      exp_q.push_back(ref_sample(acc_m));
      acc_m = acc_m + fc;
      exp   = exp_q.pop_front();
    end
    #1;
    check(name, outp, exp);
    @(negedge clk);
  endtask

  typedef struct {
    bit          restart;
    logic [22:0] fc;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit restart, input logic [22:0] fc, input logic [7:0] exp);
    vec_t v;
    v.restart = restart;
    v.fc      = fc;
    v.exp     = exp;
    return v;
  endfunction

  initial begin
    logic [7:0] seq8[11];
    logic [7:0] prev, lo, hi, held;
    int         last_zc, cyc;
    logic [22:0] fc;

    rst      = 1'b1;
    fcontrol = '0;
    @(negedge clk);

    // Eighth-cycle tone, Nyquist tone and a step of -1 LSB, all from reset.
    seq8 = '{8'd128, 8'd128, 8'd218, 8'd255, 8'd218, 8'd127,
             8'd37, 8'd0, 8'd37, 8'd128, 8'd218};
    foreach (seq8[i]) vecs.push_back(mk(i == 0, 23'h100000, seq8[i]));
    vecs.push_back(mk(1, 23'h400000, 8'd128));
    vecs.push_back(mk(0, 23'h400000, 8'd128));
    vecs.push_back(mk(0, 23'h400000, 8'd127));
    vecs.push_back(mk(0, 23'h400000, 8'd128));
    vecs.push_back(mk(0, 23'h400000, 8'd127));
    vecs.push_back(mk(0, 23'h400000, 8'd128));
    vecs.push_back(mk(1, 23'h7FFFFF, 8'd128));
    vecs.push_back(mk(0, 23'h7FFFFF, 8'd128));
    vecs.push_back(mk(0, 23'h7FFFFF, 8'd127));
    vecs.push_back(mk(0, 23'h7FFFFF, 8'd127));

    foreach (vecs[i]) begin
      if (vecs[i].restart) begin
        for (int k = 0; k < 3; k++) tick(1'b1, 23'($urandom()), "reset_hold");
      end
      tick(1'b0, vecs[i].fc, "vec_model");
      check("vec_table", outp, vecs[i].exp);
    end

    // Slow tone for 200 us: full swing, zero-crossing spacing of ~682.7 clocks.
    for (int k = 0; k < 3; k++) tick(1'b1, 23'h001800, "reset_hold");
    lo = 8'd255; hi = 8'd0; prev = 8'd128; last_zc = -1;
    for (cyc = 0; cyc < 20000; cyc++) begin
      tick(1'b0, 23'h001800, "slow_model");
      if (outp < lo) lo = outp;
      if (outp > hi) hi = outp;
      if (cyc > 2 && ((prev < 8'd128) != (outp < 8'd128))) begin
        if (last_zc >= 0) check_range("zc_spacing", cyc - last_zc, 682, 683);
        last_zc = cyc;
      end
      prev = outp;
    end
    check("slow_min", lo, 8'd0);
    check("slow_max", hi, 8'd255);

    // Faster tone mid-run: phase continues from the running accumulator.
    for (int k = 0; k < 3000; k++) tick(1'b0, 23'h003800, "switch_model");

    // Step of -1 phase LSB per clock through the wrap point.
    for (int k = 0; k < 3000; k++) tick(1'b0, 23'h7FFFFF, "wrap_model");

    // Frozen tuning word: after the pipeline drains the output holds.
    tick(1'b0, 23'h0, "freeze_model");
    tick(1'b0, 23'h0, "freeze_model");
    held = outp;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 23'h0, "freeze_model");
      check("freeze_hold", outp, held);
    end

    // Random tuning words in bursts with occasional mid-run resets.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 7) == 0) tick(1'b1, 23'($urandom()), "rand_reset");
      case ($urandom_range(0, 3))
        0:       fc = 23'($urandom_range(0, 32'h3FFF));
        1:       fc = 23'($urandom());
        2:       fc = 23'h7FFFFF - 23'($urandom_range(0, 255));
        default: fc = 23'h400000 + 23'($urandom_range(0, 15));
      endcase
      for (int k = 0; k < $urandom_range(5, 60); k++) tick(1'b0, fc, "rand_model");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
